// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB bridge: accepts a read/write command, runs one
// APB transfer with a bounded wait, and returns a registered response.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [5:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [5:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a command transfers on the rising edge where cmd_valid_i and
  // cmd_ready_o are both high; a response transfers on the edge where rsp_valid_o
  // and rsp_ready_i are both high. Valid never depends on ready.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] wait_cnt;

  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state         <= S_IDLE;
      wait_cnt      <= 8'd0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= 32'd0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= 6'd0;
      pwdata_o      <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            if (cmd_addr_i[1:0] == 2'b00) begin
              pwrite_o <= cmd_write_i;
              paddr_o  <= cmd_addr_i;
              pwdata_o <= cmd_wdata_i;
              state    <= S_LOAD;
            end else begin
              // Misaligned: answer with an error without touching the bus.
              rsp_valid_o   <= 1'b1;
              rsp_err_o     <= 1'b1;
              rsp_timeout_o <= 1'b0;
              rsp_rdata_o   <= 32'd0;
              state         <= S_RESP;
            end
          end
        end
        S_LOAD: begin
          psel_o   <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= S_SETUP;
        end
        S_SETUP: begin
          penable_o <= 1'b1;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= pwrite_o ? 32'd0 : prdata_i;
            state         <= S_RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= 32'd0;
            state         <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          psel_o      <= 1'b0;
          penable_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized bench for apb_master_bridge; expectations come from a
// transaction-level model of latency, wait-state and error rules.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [5:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [5:0]  paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  apb_master_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    check({tag, "_rsp_timeout"}, 32'(rsp_timeout_o), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, "_psel_penable"}, {30'd0, psel_o, penable_o}, 32'd0);
    check({tag, "_pwrite"}, 32'(pwrite_o), 32'd0);
    check({tag, "_paddr"}, 32'(paddr_o), 32'd0);
    check({tag, "_pwdata"}, pwdata_o, 32'd0);
  endtask

  // Driver: issue one command at a negedge, play an APB slave with `w` wait
  // states, hold the response for `hold` cycles, then consume it.
  task automatic run_txn(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                         input int w, input logic slverr, input logic [31:0] prd,
                         input int hold, input bit hold_valid);
    int cyc, acc, setup_n, exp_acc, exp_lat;
    bit mis, tmo, busy_ok, addr_ok, stable_ok;
    logic exp_err;
    logic [31:0] snap_rd;
    logic [1:0] snap_flags;

    // Reference model
    mis     = (addr[1:0] != 2'b00);
    tmo     = !mis && (w >= TIMEOUT);
    exp_acc = mis ? 0 : ((w + 1 < TIMEOUT) ? w + 1 : TIMEOUT);
    exp_lat = mis ? 1 : 3 + exp_acc;
    exp_err = mis || tmo || slverr;
    exp_q.push_back((mis || tmo || wr) ? 32'd0 : prd);

    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);

    cyc = 0; acc = 0; setup_n = 0; busy_ok = 1; addr_ok = 1;
    while (cyc <= 100) begin
      @(negedge clk_i);
      cyc++;
      if (!hold_valid) cmd_valid_i = 1'b0;
      if (rsp_valid_o) break;
      if (cmd_ready_o) busy_ok = 0;
      if (psel_o && (paddr_o !== addr || pwrite_o !== wr || pwdata_o !== wdata)) addr_ok = 0;
      if (psel_o && penable_o) begin
        acc++;
        pready_i  = (acc == w + 1);
        pslverr_i = (acc == w + 1) ? slverr : 1'($urandom_range(0, 1));
        prdata_i  = (acc == w + 1) ? prd : $urandom;
      end else begin
        pready_i = 1'b0;
        if (psel_o) setup_n++;
      end
    end
    cmd_valid_i = 1'b0;
    pready_i    = 1'b0;

    check("rsp_within_bound", 32'(cyc <= 100), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("access_cycles", 32'(acc), 32'(exp_acc));
    check("setup_cycles", 32'(setup_n), mis ? 32'd0 : 32'd1);
    check("busy_not_ready", 32'(busy_ok), 32'd1);
    check("apb_addr_ctrl_data", 32'(addr_ok), 32'd1);
    check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    check("rsp_timeout", 32'(rsp_timeout_o), 32'(tmo));
    check("rsp_rdata", rsp_rdata_o, exp_q.pop_front());
    check("bus_idle_in_resp", {30'd0, psel_o, penable_o}, 32'd0);

    snap_rd = rsp_rdata_o;
    snap_flags = {rsp_err_o, rsp_timeout_o};
    stable_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (!rsp_valid_o || rsp_rdata_o !== snap_rd || {rsp_err_o, rsp_timeout_o} !== snap_flags)
        stable_ok = 0;
    end
    if (hold > 0) check("rsp_stable_while_held", 32'(stable_ok), 32'd1);

    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_hs", 32'(rsp_valid_o), 32'd0);
    check("cmd_ready_after_hs", 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    resetn_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; rsp_ready_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");
    resetn_i = 1'b1;
    @(negedge clk_i);

    // Directed cases
    run_txn(1'b1, 6'h08, 32'hA5A5_0001, 0, 1'b0, 32'hDEAD_BEEF, 0, 0);
    run_txn(1'b0, 6'h3C, 32'h0, 1, 1'b0, 32'h1234_5678, 0, 0);
    run_txn(1'b0, 6'h10, 32'h0, 0, 1'b1, 32'h0BAD_0BAD, 0, 0);
    run_txn(1'b0, 6'h20, 32'h0, 40, 1'b0, 32'h5555_AAAA, 0, 0);
    run_txn(1'b0, 6'h24, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, 0, 0);
    run_txn(1'b1, 6'h28, 32'h1357_9BDF, TIMEOUT, 1'b0, 32'h0, 0, 0);
    run_txn(1'b0, 6'h05, 32'h0, 0, 1'b0, 32'h7777_7777, 0, 0);
    run_txn(1'b0, 6'h14, 32'h0, 2, 1'b0, 32'h89AB_CDEF, 5, 1);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
              int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    // Reset during ACCESS aborts the transfer with no response
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 6'h30; cmd_wdata_i = 32'hFACE_0001;
    begin
      int acc_seen;
      acc_seen = 0;
      for (int i = 0; i < 40 && acc_seen < 3; i++) begin
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        if (psel_o && penable_o) acc_seen++;
      end
      check("reached_access", 32'(acc_seen), 32'd3);
    end
    resetn_i = 1'b0;
    @(negedge clk_i);
    check_reset_values("mid_access_reset");
    resetn_i = 1'b1;
    begin
      bit quiet;
      quiet = 1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk_i);
        if (rsp_valid_o || psel_o) quiet = 0;
      end
      check("no_rsp_after_reset", 32'(quiet), 32'd1);
    end
    check("cmd_ready_after_reset", 32'(cmd_ready_o), 32'd1);

    run_txn(1'b0, 6'h04, 32'h0, 3, 1'b0, 32'h2468_ACE0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum ACCESS-phase cycles to wait for pready_i (legal range 2..255).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port resetn_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid_i, input, 1 bit: command request.
REQ-005 The block SHALL have port cmd_ready_o, output, 1 bit: command accepted when high together with cmd_valid_i.
REQ-006 The block SHALL have port cmd_write_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port cmd_addr_i, input, 6 bits: byte address.
REQ-008 The block SHALL have port cmd_wdata_i, input, 32 bits: write data.
REQ-009 The block SHALL have port rsp_valid_o, output, 1 bit: response available.
REQ-010 The block SHALL have port rsp_ready_i, input, 1 bit: response consumed when high together with rsp_valid_o.
REQ-011 The block SHALL have port rsp_rdata_o, output, 32 bits: read data.
REQ-012 The block SHALL have port rsp_err_o, output, 1 bit: transfer failed.
REQ-013 The block SHALL have port rsp_timeout_o, output, 1 bit: the failure was a timeout.
REQ-014 The block SHALL have the APB ports psel_o (out, 1), penable_o (out, 1), pwrite_o (out, 1), paddr_o (out, 6), pwdata_o (out, 32), prdata_i (in, 32), pready_i (in, 1) and pslverr_i (in, 1).

Function
REQ-015 The block SHALL drive every output from a register and SHALL have no combinational path from input to output.
REQ-016 The block SHALL implement the states IDLE, SETUP, ACCESS and RESP.
REQ-017 In IDLE, cmd_ready_o SHALL be 1; in every other state it SHALL be 0, so at most one transfer is outstanding.
REQ-018 On acceptance in IDLE with cmd_addr_i[1:0]==0, the block SHALL latch write, addr and wdata into pwrite_o, paddr_o and pwdata_o, and go to SETUP the next cycle.
REQ-019 On acceptance with cmd_addr_i[1:0]!=0, the block SHALL make no APB transfer and SHALL go to RESP with rsp_err_o=1, rsp_timeout_o=0 and rsp_rdata_o=0.
REQ-020 SETUP SHALL last exactly one cycle with psel_o=1 and penable_o=0, then go to ACCESS.
REQ-021 In ACCESS, psel_o and penable_o SHALL be 1, and paddr_o, pwrite_o and pwdata_o SHALL stay stable.
REQ-022 In ACCESS with pready_i=1, the block SHALL go to RESP and capture: rsp_err_o=pslverr_i, rsp_timeout_o=0, rsp_rdata_o=prdata_i for a read or 0 for a write.
REQ-023 The block SHALL count ACCESS cycles with an 8-bit wait counter cleared on entry to SETUP.
REQ-024 If pready_i is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the block SHALL go to RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
REQ-025 If pready_i=1 in the TIMEOUT_CYCLES-th ACCESS cycle, it SHALL be a normal completion and SHALL NOT be treated as a timeout.
REQ-026 psel_o and penable_o SHALL be 0 in the cycle after leaving ACCESS, and in IDLE and RESP.
REQ-027 In RESP, rsp_valid_o SHALL be 1 and the rsp_* fields SHALL stay stable until rsp_ready_i=1.
REQ-028 The handshake in RESP SHALL return the block to IDLE the next cycle, with rsp_valid_o=0.
REQ-029 Minimum latency SHALL be 4 cycles from command acceptance to rsp_valid_o with zero wait states.
REQ-030 cmd_valid_i asserted in non-IDLE states SHALL be ignored, and the command SHALL not be lost if the requester holds it until cmd_ready_o.

Reset
REQ-031 While resetn_i=0 at a clock edge, the block SHALL enter IDLE.
REQ-032 Reset SHALL set cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_timeout_o=0 and rsp_rdata_o=0.
REQ-033 Reset SHALL set psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0 and the wait counter to 0.
REQ-034 Reset in any state, including mid-ACCESS, SHALL abort the transfer without producing a response.

Verification
REQ-035 Write addr 0x08, data 0xA5A5_0001, pready_i=1 at the first ACCESS cycle -> SETUP/ACCESS one cycle each; rsp_valid_o at acceptance+4 with err=0 and rdata=0.
REQ-036 Read addr 0x3C, slave gives 1 wait state, prdata_i=0x1234_5678 -> ACCESS lasts 2 cycles; rsp_rdata_o=0x1234_5678, err=0.
REQ-037 Read with pready_i=1 and pslverr_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
REQ-038 pready_i stuck at 0 with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then err=1, timeout=1, rdata=0, psel_o=0.
REQ-039 Command addr 0x05 -> no psel_o pulse; error response at acceptance+1.
REQ-040 rsp_ready_i held 0 for 5 cycles, then resetn_i=0 mid-ACCESS on a later transfer -> response held stable until handshake; after reset, all outputs at reset values and no response.
